switch_input: RTL and testbench
===============================

Name: switch_input

Overview:
Debounced, handshaked front-end for the board switches. It feeds the processor's SWITCH_ADDR read path and replaces direct sampling of SW[16:0] and SW[17] inside the fetch/deference state machine. The processor raises req when it dereferences SWITCH_ADDR. The block then waits for a full debounced press/release of the strobe switch and returns the data word captured at the press, with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 17, width of the switch data field (SW[16:0])
SYNC_STAGES, 2, flip-flop synchronizer depth on every raw switch input (minimum 2)
DEBOUNCE_CYCLES, 500000, cycles a synchronized strobe level must hold before it is accepted (10 ms at 50 MHz; minimum 2)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset_n  input  1  synchronous, active-low reset
sw_data  input  DATA_WIDTH  raw, asynchronous switch data (SW[16:0])
sw_strobe  input  1  raw, asynchronous strobe switch (SW[17])
req  input  1  level request from processor; held high until valid is seen
value  output  DATA_WIDTH  captured switch word; stable from the valid pulse until the next capture
valid  output  1  one-cycle pulse, value ready for the processor
waiting  output  1  high while a request is outstanding (for an LED)
strobe_db  output  1  debounced strobe level (for debug/LED)

Behaviour:
- Interface: one clock; reset is synchronous and active-low (ports clock, reset_n).
- Reset (reset_n low at a clock edge): synchronizer registers = 0, debounce counter = 0, strobe_db = 0, value = 0, valid = 0, waiting = 0, FSM = IDLE. Reset asserted mid-transaction aborts it with no valid.
- Synchronizer: sw_data and sw_strobe each pass through SYNC_STAGES flops. The synchronized data is data_s; the synchronized strobe is strobe_s.
- Debounce:
  - Counter clears whenever strobe_s == strobe_db.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, strobe_db <= strobe_s and the counter clears.
  - Latency from a stable raw change to strobe_db change is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES is never accepted.
- The rising and falling edges of strobe_db are registered as single-cycle pulses, press and release.
- FSM:
  - IDLE: waiting=0. On req=1, go to WAIT_PRESS.
  - WAIT_PRESS: waiting=1. On press, value <= data_s (same edge) and go to WAIT_RELEASE.
  - WAIT_RELEASE: waiting=1. On release, go to DONE. Data changes during this state are ignored.
  - DONE: valid=1 for exactly this cycle, waiting=0, then IDLE.
- Strobe already high when req rises: a press is not generated. The user must release, then press and release again.
- Strobe activity while in IDLE is tracked by the debouncer but never changes value or valid.
- req dropped in WAIT_PRESS or WAIT_RELEASE: return to IDLE next cycle with no valid. value keeps its last contents (a capture already made in WAIT_RELEASE is not reverted).
- req still high on the cycle after DONE: IDLE sees it and starts a new transaction. The processor must drop req on valid.
- Latency from debounced release to valid is 2 cycles (release pulse, then DONE).
- No arithmetic on data. Counter width is clog2(DEBOUNCE_CYCLES); the counter never wraps because it clears at terminal count.

Test Plan:
(Simulation uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2.)
1. Basic read: reset_n=0 for 2 cycles, then 1. Hold req=1, sw_data=17'h0ABCD, raise sw_strobe for 10 cycles, then drop it -> value=17'h0ABCD, single valid pulse 2 cycles after strobe_db falls, waiting high from req until valid.
2. Bounce: toggle sw_strobe 1/0 every 2 cycles for 12 cycles, then hold 1 for 10 cycles, then 0 for 10 cycles -> exactly one press and one release, exactly one valid.
3. Data changes after press: press with sw_data=17'h00011, change to 17'h1FFFF before release -> value=17'h00011.
4. Strobe pre-held: sw_strobe=1 and debounced before req rises -> no valid on the first release. The next full press with sw_data=17'h00042 gives value=17'h00042 and one valid.
5. Abort: drop req in WAIT_RELEASE, then release the strobe -> valid stays 0, FSM returns to IDLE, waiting=0.
6. Reset mid-operation: reset_n=0 in WAIT_RELEASE with value=17'h00123 -> value=0, valid=0, waiting=0, strobe_db=0 on the next edge, and no spurious valid after reset is released.

Source files
------------

// File: rtl/switch_input.sv
// Debounced, handshaked switch front-end for the processor's SWITCH_ADDR read path.
// A request is answered after one complete debounced press/release of the strobe switch.
module switch_input #(
  parameter int DATA_WIDTH      = 17,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] sw_data,
  input  logic                  sw_strobe,
  input  logic                  req,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  valid,
  output logic                  waiting,
  output logic                  strobe_db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] data_sync [SYNC_STAGES];
  logic                  strobe_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] data_s;
  logic                  strobe_s;

  logic [CNT_W-1:0]      cnt_reg;
  logic                  strobe_db_reg;
  logic                  strobe_db_dly_reg;
  logic                  press_reg;
  logic                  release_reg;

  state_t                state_reg;
  state_t                state_next;
  logic                  capture;
  logic [DATA_WIDTH-1:0] value_reg;

  // Synchronizer chains; stage 0 samples the raw asynchronous switches.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          data_sync[gi]   <= '0;
          strobe_sync[gi] <= 1'b0;
        end else if (gi == 0) begin
          data_sync[gi]   <= sw_data;
          strobe_sync[gi] <= sw_strobe;
        end else begin
          data_sync[gi]   <= data_sync[(gi > 0) ? gi - 1 : 0];
          strobe_sync[gi] <= strobe_sync[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign data_s   = data_sync[SYNC_STAGES-1];
  assign strobe_s = strobe_sync[SYNC_STAGES-1];

  // A new strobe level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_reg       <= '0;
      strobe_db_reg <= 1'b0;
    end else if (strobe_s == strobe_db_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_TERM) begin
      strobe_db_reg <= strobe_s;
      cnt_reg       <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      strobe_db_dly_reg <= 1'b0;
      press_reg         <= 1'b0;
      release_reg       <= 1'b0;
    end else begin
      strobe_db_dly_reg <= strobe_db_reg;
      press_reg         <= strobe_db_reg & ~strobe_db_dly_reg;
      release_reg       <= ~strobe_db_reg & strobe_db_dly_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Dropping req aborts an outstanding request, even on the cycle of a press or release.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!req) begin
          state_next = IDLE;
        end else if (press_reg) begin
          capture    = 1'b1;
          state_next = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!req) state_next = IDLE;
        else if (release_reg) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value_reg <= '0;
    end else if (capture) begin
      value_reg <= data_s;
    end
  end

  assign value     = value_reg;
  assign valid     = (state_reg == DONE);
  assign waiting   = (state_reg == WAIT_PRESS) || (state_reg == WAIT_RELEASE);
  assign strobe_db = strobe_db_reg;

endmodule

// File: tb/tb_switch_input.sv
// Directed bench for switch_input with short debounce; the processor side drops req on valid.
module tb_switch_input;

  localparam int DW = 17;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] sw_data;
  logic          sw_strobe;
  logic          req;
  logic [DW-1:0] value;
  logic          valid;
  logic          waiting;
  logic          strobe_db;

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  int valid_count = 0;
  int rise_count = 0;
  int fall_count = 0;
  int last_fall_cyc = -1;
  int last_valid_cyc = -1;
  logic db_prev = 1'b0;

  switch_input #(
    .DATA_WIDTH(DW),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .sw_data(sw_data),
    .sw_strobe(sw_strobe),
    .req(req),
    .value(value),
    .valid(valid),
    .waiting(waiting),
    .strobe_db(strobe_db)
  );

  always #5 clock = ~clock;

  // Edge monitor: samples the values held during the cycle just ending.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (valid) begin
      valid_count    <= valid_count + 1;
      last_valid_cyc <= cyc;
    end
    if (strobe_db && !db_prev) rise_count <= rise_count + 1;
    if (!strobe_db && db_prev) begin
      fall_count    <= fall_count + 1;
      last_fall_cyc <= cyc;
    end
    db_prev <= strobe_db;
  end

  // One clock, sampled 1 ns after the edge; the processor drops req when it sees valid.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (valid) req = 1'b0;
    end
  endtask

  task automatic wait_valid(input string name, input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clock);
      #1;
      if (valid) begin
        seen = 1'b1;
        req  = 1'b0;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s: valid observed=0 required=1 within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    sw_data   = '0;
    sw_strobe = 1'b0;
    req       = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    tests_run++;
    if ({value, valid, waiting, strobe_db} !== {17'h0, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_state: value=%h valid=%b waiting=%b strobe_db=%b required 0/0/0/0",
               value, valid, waiting, strobe_db);
    end
    $display("[TB] reset: value=%h valid=%b waiting=%b", value, valid, waiting);
  endtask

  task automatic test_basic_read;
    int   v0;
    logic seen;
    v0      = valid_count;
    req     = 1'b1;
    sw_data = 17'h0ABCD;
    tick(1);
    tests_run++;
    if (waiting !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_waiting_on_req: waiting=%b required 1", waiting);
    end
    sw_strobe = 1'b1;
    tick(10);
    tests_run++;
    if (waiting !== 1'b1 || strobe_db !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_pressed: waiting=%b strobe_db=%b required 1/1", waiting, strobe_db);
    end
    sw_strobe = 1'b0;
    wait_valid("basic_valid", 30, seen);
    tests_run++;
    if (value !== 17'h0ABCD || waiting !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_value: value=%h waiting=%b required 0abcd/0", value, waiting);
    end
    tick(3);
    tests_run++;
    if (last_valid_cyc - last_fall_cyc !== 2) begin
      tests_failed++;
      $display("FAIL basic_latency: release-to-valid=%0d required 2", last_valid_cyc - last_fall_cyc);
    end
    tests_run++;
    if (valid_count - v0 !== 1) begin
      tests_failed++;
      $display("FAIL basic_pulse_count: valid pulses=%0d required 1", valid_count - v0);
    end
    $display("[TB] basic read: value=%h pulses=%0d", value, valid_count - v0);
  endtask

  task automatic test_bounce;
    int v0, r0, f0;
    v0      = valid_count;
    r0      = rise_count;
    f0      = fall_count;
    req     = 1'b1;
    sw_data = 17'h15555;
    for (int i = 0; i < 6; i++) begin
      sw_strobe = ~i[0];
      tick(2);
    end
    sw_strobe = 1'b1;
    tick(10);
    sw_strobe = 1'b0;
    tick(10);
    tick(5);
    tests_run++;
    if (rise_count - r0 !== 1 || fall_count - f0 !== 1) begin
      tests_failed++;
      $display("FAIL bounce_edges: press=%0d release=%0d required 1/1", rise_count - r0, fall_count - f0);
    end
    tests_run++;
    if (valid_count - v0 !== 1 || value !== 17'h15555) begin
      tests_failed++;
      $display("FAIL bounce_valid: pulses=%0d value=%h required 1/15555", valid_count - v0, value);
    end
    $display("[TB] bounce: presses=%0d releases=%0d pulses=%0d", rise_count - r0, fall_count - f0, valid_count - v0);
  endtask

  task automatic test_data_change;
    logic seen;
    req       = 1'b1;
    sw_data   = 17'h00011;
    sw_strobe = 1'b1;
    tick(10);
    sw_data = 17'h1FFFF;
    tick(4);
    sw_strobe = 1'b0;
    wait_valid("data_change_valid", 30, seen);
    tests_run++;
    if (value !== 17'h00011) begin
      tests_failed++;
      $display("FAIL data_change_value: value=%h required 00011", value);
    end
    tick(3);
    $display("[TB] data change: value=%h", value);
  endtask

  task automatic test_preheld;
    int   v0;
    logic seen;
    v0        = valid_count;
    req       = 1'b0;
    sw_data   = 17'h00099;
    sw_strobe = 1'b1;
    tick(10);
    tests_run++;
    if (strobe_db !== 1'b1 || waiting !== 1'b0 || valid_count !== v0) begin
      tests_failed++;
      $display("FAIL preheld_idle: strobe_db=%b waiting=%b pulses=%0d required 1/0/0",
               strobe_db, waiting, valid_count - v0);
    end
    req = 1'b1;
    tick(2);
    sw_strobe = 1'b0;
    tick(12);
    tests_run++;
    if (valid_count !== v0 || waiting !== 1'b1) begin
      tests_failed++;
      $display("FAIL preheld_first_release: pulses=%0d waiting=%b required 0/1", valid_count - v0, waiting);
    end
    sw_data   = 17'h00042;
    sw_strobe = 1'b1;
    tick(10);
    sw_strobe = 1'b0;
    wait_valid("preheld_valid", 30, seen);
    tick(3);
    tests_run++;
    if (value !== 17'h00042 || valid_count - v0 !== 1) begin
      tests_failed++;
      $display("FAIL preheld_value: value=%h pulses=%0d required 00042/1", value, valid_count - v0);
    end
    $display("[TB] preheld: value=%h pulses=%0d", value, valid_count - v0);
  endtask

  task automatic test_abort;
    int v0;
    v0        = valid_count;
    req       = 1'b1;
    sw_data   = 17'h00777;
    sw_strobe = 1'b1;
    tick(10);
    tests_run++;
    if (waiting !== 1'b1 || value !== 17'h00777) begin
      tests_failed++;
      $display("FAIL abort_captured: waiting=%b value=%h required 1/00777", waiting, value);
    end
    req = 1'b0;
    tick(2);
    sw_strobe = 1'b0;
    tick(15);
    tests_run++;
    if (valid_count !== v0 || waiting !== 1'b0 || value !== 17'h00777) begin
      tests_failed++;
      $display("FAIL abort_no_valid: pulses=%0d waiting=%b value=%h required 0/0/00777",
               valid_count - v0, waiting, value);
    end
    $display("[TB] abort: pulses=%0d waiting=%b value=%h", valid_count - v0, waiting, value);
  endtask

  task automatic test_reset_mid;
    int v0;
    req       = 1'b1;
    sw_data   = 17'h00123;
    sw_strobe = 1'b1;
    tick(10);
    tests_run++;
    if (value !== 17'h00123 || waiting !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_setup: value=%h waiting=%b required 00123/1", value, waiting);
    end
    reset_n = 1'b0;
    req     = 1'b0;
    tick(1);
    tests_run++;
    if ({value, valid, waiting, strobe_db} !== {17'h0, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_mid_clear: value=%h valid=%b waiting=%b strobe_db=%b required 0/0/0/0",
               value, valid, waiting, strobe_db);
    end
    v0      = valid_count;
    reset_n = 1'b1;
    tick(10);
    sw_strobe = 1'b0;
    tick(15);
    tests_run++;
    if (valid_count !== v0 || waiting !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_spurious: pulses=%0d waiting=%b required 0/0", valid_count - v0, waiting);
    end
    $display("[TB] reset mid-op: pulses after reset=%0d", valid_count - v0);
  endtask

  initial begin
    test_reset;
    test_basic_read;
    test_bounce;
    test_data_change;
    test_preheld;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
